// File: rtl/power_domain_ctrl.sv
// power_domain_ctrl: ordered, timed power-down/up sequencer for one switchable domain (switch timeout under POWER_CTRL_SW_TIMEOUT_EN)
module power_domain_ctrl #(
    parameter int STEP_CYC   = 2,
    parameter int SW_TIMEOUT = 64
) (
    input  logic ck,
    input  logic rst,
    input  logic pwr_on_req,
    output logic pwr_on_ack,
    output logic pwr_busy,
    output logic clk_en,
    output logic iso_en,
    output logic ret_save,
    output logic ret_restore,
    output logic dom_rst,
    output logic sw_en,
    input  logic sw_ack,
    output logic sw_err
);
    typedef enum logic [3:0] {
        ON, CLK_OFF, ISO, SAVE, RST, SW_OFF, OFF, SW_ON, RESTORE, RST_REL, ISO_OFF, CLK_ON
    } state_t;

    state_t st, nxt;
    logic [7:0] cnt;
    logic step_done, tmo;

    // {clk_en, iso_en, ret_save, ret_restore, dom_rst, sw_en, pwr_on_ack, pwr_busy}
    function automatic logic [7:0] outs(input state_t s);
        logic [7:0] o;
        case (s)
            CLK_OFF: o = 8'b0_0_0_0_0_1_1_1;
            ISO:     o = 8'b0_1_0_0_0_1_1_1;
            SAVE:    o = 8'b0_1_1_0_0_1_1_1;
            RST:     o = 8'b0_1_0_0_1_1_1_1;
            SW_OFF:  o = 8'b0_1_0_0_1_0_1_1;
            OFF:     o = 8'b0_1_0_0_1_0_0_0;
            SW_ON:   o = 8'b0_1_0_0_1_1_0_1;
            RESTORE: o = 8'b0_1_0_1_1_1_0_1;
            RST_REL: o = 8'b0_1_0_0_0_1_0_1;
            ISO_OFF: o = 8'b0_0_0_0_0_1_0_1;
            CLK_ON:  o = 8'b1_0_0_0_0_1_0_1;
            default: o = 8'b1_0_0_0_0_1_1_0;
        endcase
        return o;
    endfunction

    assign step_done = cnt == 8'(STEP_CYC - 1);

`ifdef POWER_CTRL_SW_TIMEOUT_EN
    logic [15:0] tcnt;
    assign tmo = tcnt == 16'(SW_TIMEOUT - 1) && ((st == SW_OFF && sw_ack) || (st == SW_ON && !sw_ack));
    // switch-wait timer clears on every entry; sw_err latches on expiry until reset
    always_ff @(posedge ck) begin
        if (rst) begin
            tcnt   <= '0;
            sw_err <= 1'b0;
        end else begin
            tcnt   <= (nxt == st && (st == SW_OFF || st == SW_ON)) ? tcnt + 16'd1 : '0;
            sw_err <= sw_err | tmo;
        end
    end
`else
    assign tmo    = 1'b0;
    assign sw_err = SW_TIMEOUT < 1;
`endif

    // next state: request sampled only in ON/OFF, timed steps advance on step_done
    always_comb begin
        nxt = st;
        case (st)
            ON:      nxt = pwr_on_req ? ON : CLK_OFF;
            CLK_OFF: nxt = step_done ? ISO : st;
            ISO:     nxt = step_done ? SAVE : st;
            SAVE:    nxt = step_done ? RST : st;
            RST:     nxt = step_done ? SW_OFF : st;
            SW_OFF:  nxt = (!sw_ack || tmo) ? OFF : st;
            OFF:     nxt = (pwr_on_req && !sw_err) ? SW_ON : OFF;
            SW_ON:   nxt = sw_ack ? RESTORE : tmo ? OFF : st;
            RESTORE: nxt = step_done ? RST_REL : st;
            RST_REL: nxt = step_done ? ISO_OFF : st;
            ISO_OFF: nxt = step_done ? CLK_ON : st;
            CLK_ON:  nxt = step_done ? ON : st;
            default: nxt = ON;
        endcase
    end

    // state, step counter and outputs all registered from the state being entered
    always_ff @(posedge ck) begin
        if (rst) begin
            st  <= ON;
            cnt <= '0;
            {clk_en, iso_en, ret_save, ret_restore, dom_rst, sw_en, pwr_on_ack, pwr_busy} <= outs(ON);
        end else begin
            st  <= nxt;
            cnt <= (nxt != st) ? '0 : cnt + 8'd1;
            {clk_en, iso_en, ret_save, ret_restore, dom_rst, sw_en, pwr_on_ack, pwr_busy} <= outs(nxt);
        end
    end
endmodule

// File: tb/tb_power_domain_ctrl.sv
// tb_power_domain_ctrl: table-driven and directed checks of the power sequencer
module tb_power_domain_ctrl;
    logic ck = 1'b0;
    logic rst = 1'b1;
    logic pwr_on_req = 1'b1;
    logic pwr_on_ack, pwr_busy, clk_en, iso_en, ret_save, ret_restore, dom_rst, sw_en, sw_ack, sw_err;
    logic [7:0] hist = '1;
    int dly = 3;
    logic stuck = 1'b0;
    int applied = 0;
    int errs = 0;

    // {clk_en, iso_en, ret_save, ret_restore, dom_rst, sw_en, pwr_on_ack, pwr_busy, sw_err}
    localparam logic [8:0] P_ON      = 9'b1_0_0_0_0_1_1_0_0;
    localparam logic [8:0] P_CLKOFF  = 9'b0_0_0_0_0_1_1_1_0;
    localparam logic [8:0] P_ISO     = 9'b0_1_0_0_0_1_1_1_0;
    localparam logic [8:0] P_SAVE    = 9'b0_1_1_0_0_1_1_1_0;
    localparam logic [8:0] P_RST     = 9'b0_1_0_0_1_1_1_1_0;
    localparam logic [8:0] P_SWOFF   = 9'b0_1_0_0_1_0_1_1_0;
    localparam logic [8:0] P_OFF     = 9'b0_1_0_0_1_0_0_0_0;
    localparam logic [8:0] P_SWON    = 9'b0_1_0_0_1_1_0_1_0;
    localparam logic [8:0] P_RESTORE = 9'b0_1_0_1_1_1_0_1_0;
    localparam logic [8:0] P_RSTREL  = 9'b0_1_0_0_0_1_0_1_0;
    localparam logic [8:0] P_ISOOFF  = 9'b0_0_0_0_0_1_0_1_0;
    localparam logic [8:0] P_CLKON   = 9'b1_0_0_0_0_1_0_1_0;

    typedef struct {
        logic       req;
        logic [8:0] exp;
    } vec_t;
    vec_t tbl[$];

    wire [8:0] obs = {clk_en, iso_en, ret_save, ret_restore, dom_rst, sw_en, pwr_on_ack, pwr_busy, sw_err};

    power_domain_ctrl #(.STEP_CYC(2), .SW_TIMEOUT(8)) dut (
        .ck(ck), .rst(rst), .pwr_on_req(pwr_on_req), .pwr_on_ack(pwr_on_ack), .pwr_busy(pwr_busy),
        .clk_en(clk_en), .iso_en(iso_en), .ret_save(ret_save), .ret_restore(ret_restore),
        .dom_rst(dom_rst), .sw_en(sw_en), .sw_ack(sw_ack), .sw_err(sw_err)
    );

    always #5 ck = ~ck;

    always @(posedge ck) hist <= {hist[6:0], sw_en};
    assign sw_ack = stuck ? 1'b0 : (dly == 0 ? sw_en : hist[dly-1]);

    always @(negedge ck) begin
        if (rst === 1'b0) begin
            if (ret_save && ret_restore) begin
                errs++;
                $display("FAIL inv_ret: ret_save=%b ret_restore=%b both high", ret_save, ret_restore);
            end
            if (!iso_en && !(sw_en && sw_ack && !dom_rst)) begin
                errs++;
                $display("FAIL inv_iso: iso_en=0 with sw_en=%b sw_ack=%b dom_rst=%b, required 1/1/0", sw_en, sw_ack, dom_rst);
            end
        end
    end

    task automatic add(input logic r, input logic [8:0] e, input int n);
        for (int i = 0; i < n; i++) tbl.push_back('{req: r, exp: e});
    endtask

    task automatic step(input logic r, input logic [8:0] e, input string name);
        pwr_on_req = r;
        @(posedge ck);
        @(negedge ck);
        applied++;
        if (obs !== e) begin
            errs++;
            $display("FAIL %s: got %b expected %b", name, obs, e);
        end
    endtask

    task automatic run(input logic r, input int n);
        pwr_on_req = r;
        repeat (n) @(posedge ck);
        @(negedge ck);
    endtask

    initial begin
        add(1, P_ON, 10);
        add(0, P_CLKOFF, 2);
        add(0, P_ISO, 2);
        add(0, P_SAVE, 2);
        add(0, P_RST, 2);
        add(0, P_SWOFF, 4);
        add(0, P_OFF, 3);
        add(1, P_SWON, 4);
        add(1, P_RESTORE, 2);
        add(1, P_RSTREL, 2);
        add(1, P_ISOOFF, 2);
        add(1, P_CLKON, 2);
        add(1, P_ON, 2);
        repeat (5) @(posedge ck);
        @(negedge ck);
        rst = 1'b0;
        foreach (tbl[i]) step(tbl[i].req, tbl[i].exp, $sformatf("tbl[%0d]", i));
        dly = 0;
        run(0, 2);
        run(1, 1);
        run(0, 6);
        step(0, P_OFF, "pulse_dn_off");
        step(0, P_OFF, "pulse_dn_hold1");
        step(0, P_OFF, "pulse_dn_hold2");
        run(1, 2);
        run(0, 1);
        run(1, 5);
        step(1, P_CLKON, "pulse_up_clkon");
        step(1, P_ON, "pulse_up_on");
        step(1, P_ON, "pulse_up_hold");
        run(0, 2);
        run(1, 7);
        step(1, P_OFF, "late_req_off");
        step(1, P_SWON, "late_req_swon");
        run(1, 7);
        step(1, P_CLKON, "late_req_clkon");
        step(1, P_ON, "late_req_on");
        run(0, 4);
        step(0, P_SAVE, "save");
        rst = 1'b1;
        step(0, P_ON, "rst_in_save");
        rst = 1'b0;
        step(1, P_ON, "post_rst");
`ifdef POWER_CTRL_SW_TIMEOUT_EN
        run(0, 9);
        step(0, P_OFF, "tmo_off");
        stuck = 1'b1;
        run(1, 7);
        step(1, P_SWON, "tmo_wait");
        step(1, P_OFF | 9'd1, "tmo_err");
        step(1, P_OFF | 9'd1, "tmo_ignored1");
        step(1, P_OFF | 9'd1, "tmo_ignored2");
`endif
        $display("== %0d vectors applied, %0d miscompares ==", applied, errs);
        $finish;
    end
endmodule
